systolic_seq: RTL

Sequencer for the 3x3 output-stationary systolic matrix multiplier. On a start request it latches two 3x3 operand matrices, clears the PE accumulators, and streams the operands into the array's west/north edges in diagonal-skewed order. It then waits for the pipeline to drain and pulses `done_o` when c1..c9 are valid. It sits between the host/bus interface and the `systolic` PE array; it replaces the array's internal operand ordering.

---
 rtl/systolic_pkg.sv | 23 ++
 rtl/systolic_skew_gen.sv | 27 ++
 rtl/systolic_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared constants, state encoding and counter sizing for the 3x3 systolic sequencer.
package systolic_pkg;

  localparam int N           = 3;
  localparam int FEED_CYCLES = 2 * N - 1;
  localparam int FEED_CW     = $clog2(FEED_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DRAIN_CW_DEFAULT = cnt_w(2);

endpackage

// File: rtl/systolic_skew_gen.sv
// Diagonal-skew selector: for feed step t, picks A[i][t-i] per row and B[t-j][j] per column.
module systolic_skew_gen
  import systolic_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0]  i_a   [N][N],
  input  logic [DATA_W-1:0]  i_b   [N][N],
  input  logic [FEED_CW-1:0] i_t,
  output logic [DATA_W-1:0]  o_row [N],
  output logic [DATA_W-1:0]  o_col [N]
);

  logic [DATA_W-1:0] w_am [N][N];
  logic [DATA_W-1:0] w_bm [N][N];

  // Each row/column has at most one element on the active anti-diagonal, so OR-combining is a mux.
  for (genvar gi = 0; gi < N; gi++) begin : g_outer
    for (genvar gk = 0; gk < N; gk++) begin : g_inner
      assign w_am[gi][gk] = (i_t == FEED_CW'(gi + gk)) ? i_a[gi][gk] : '0;
      assign w_bm[gk][gi] = (i_t == FEED_CW'(gk + gi)) ? i_b[gk][gi] : '0;
    end
    assign o_row[gi] = w_am[gi][0] | w_am[gi][1] | w_am[gi][2];
    assign o_col[gi] = w_bm[0][gi] | w_bm[1][gi] | w_bm[2][gi];
  end

endmodule

// File: rtl/systolic_seq.sv
// Job sequencer for the 3x3 output-stationary array: latch operands, clear PEs, feed skewed edges, drain, done.
module systolic_seq
  import systolic_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a1, a2, a3, a4, a5, a6, a7, a8, a9,
  input  logic [DATA_W-1:0] b1, b2, b3, b4, b5, b6, b7, b8, b9,
  output logic [DATA_W-1:0] row_a0, row_a1, row_a2,
  output logic [DATA_W-1:0] col_b0, col_b1, col_b2,
  output logic              pe_clr_o,
  output logic              pe_en_o,
  output logic              busy_o,
  output logic              done_o,
  output state_t            state_o
);

  localparam int DRAIN_CW = cnt_w(DRAIN_CYCLES);

  state_t              r_state, w_state_n;
  logic [FEED_CW-1:0]  r_t, w_t_n;
  logic [DRAIN_CW-1:0] r_d, w_d_n;

  logic [DATA_W-1:0] w_a_in [N][N];
  logic [DATA_W-1:0] w_b_in [N][N];
  logic [DATA_W-1:0] r_a    [N][N];
  logic [DATA_W-1:0] r_b    [N][N];
  logic [DATA_W-1:0] w_row  [N];
  logic [DATA_W-1:0] w_col  [N];
  logic [DATA_W-1:0] r_row  [N];
  logic [DATA_W-1:0] r_col  [N];
  logic              r_clr, r_en, r_busy, r_done;

  assign w_a_in[0][0] = a1;  assign w_a_in[0][1] = a2;  assign w_a_in[0][2] = a3;
  assign w_a_in[1][0] = a4;  assign w_a_in[1][1] = a5;  assign w_a_in[1][2] = a6;
  assign w_a_in[2][0] = a7;  assign w_a_in[2][1] = a8;  assign w_a_in[2][2] = a9;
  assign w_b_in[0][0] = b1;  assign w_b_in[0][1] = b2;  assign w_b_in[0][2] = b3;
  assign w_b_in[1][0] = b4;  assign w_b_in[1][1] = b5;  assign w_b_in[1][2] = b6;
  assign w_b_in[2][0] = b7;  assign w_b_in[2][1] = b8;  assign w_b_in[2][2] = b9;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_t     <= '0;
      r_d     <= '0;
    end else begin
      r_state <= w_state_n;
      r_t     <= w_t_n;
      r_d     <= w_d_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_t_n     = r_t;
    w_d_n     = r_d;
    case (r_state)
      IDLE:  if (start_i) w_state_n = CLEAR;
      CLEAR: begin
        w_state_n = FEED;
        w_t_n     = '0;
      end
      FEED: begin
        if (r_t == FEED_CW'(FEED_CYCLES - 1)) begin
          w_state_n = DRAIN;
          w_d_n     = '0;
        end else begin
          w_t_n = r_t + FEED_CW'(1);
        end
      end
      DRAIN: begin
        if (r_d == DRAIN_CW'(DRAIN_CYCLES - 1)) w_state_n = DONE;
        else                                   w_d_n     = r_d + DRAIN_CW'(1);
      end
      DONE:    w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '{default: '0};
      r_b <= '{default: '0};
    end else if (r_state == IDLE && start_i) begin
      r_a <= w_a_in;
      r_b <= w_b_in;
    end
  end

  // The skew generator sees the next step's t so the registered edges line up with the state.
  systolic_skew_gen #(.DATA_W(DATA_W)) u_skew (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_t   (w_t_n),
    .o_row (w_row),
    .o_col (w_col)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row  <= '{default: '0};
      r_col  <= '{default: '0};
      r_clr  <= 1'b0;
      r_en   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_state_n == FEED) begin
        r_row <= w_row;
        r_col <= w_col;
      end else begin
        r_row <= '{default: '0};
        r_col <= '{default: '0};
      end
      r_clr  <= (w_state_n == CLEAR);
      r_en   <= (w_state_n == FEED) || (w_state_n == DRAIN);
      r_busy <= (w_state_n == CLEAR) || (w_state_n == FEED) || (w_state_n == DRAIN);
      r_done <= (w_state_n == DONE);
    end
  end

  assign row_a0   = r_row[0];
  assign row_a1   = r_row[1];
  assign row_a2   = r_row[2];
  assign col_b0   = r_col[0];
  assign col_b1   = r_col[1];
  assign col_b2   = r_col[2];
  assign pe_clr_o = r_clr;
  assign pe_en_o  = r_en;
  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign state_o  = r_state;

endmodule
